// File: rtl/core2wb.sv
// Core req/gnt/rvalid to pipelined Wishbone B4 master: 0-cycle request-to-strobe, 1-cycle ack-to-rvalid.
// Backpressure: wb_stall or a full outstanding count withholds core_gnt; the core holds its request meanwhile.
module core2wb #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_req,
    input  logic        core_we,
    input  logic [3:0]  core_be,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,

    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [29:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stall,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic [31:0] wb_dat_i
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt;
    logic          room;
    logic          busy;
    logic          iss;
    logic          cmp;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^core_addr[1:0];

    // Room is judged on the registered count so a same-cycle ack never feeds the strobe path.
    always_comb begin
        room     = (cnt < MAX_CNT);
        busy     = (cnt != '0);
        wb_stb   = core_req & room;
        core_gnt = wb_stb & ~wb_stall;
        iss      = core_gnt;
        cmp      = (wb_ack | wb_err) & busy;
        wb_cyc   = wb_stb | busy;
        wb_we    = core_we;
        wb_adr   = core_addr[31:2];
        wb_sel   = core_be;
        wb_dat_o = core_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({iss, cmp})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Error takes priority over a simultaneous ack; acks with nothing outstanding are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rvalid <= 1'b0;
            core_err    <= 1'b0;
            core_rdata  <= 32'h0;
        end else begin
            core_rvalid <= cmp;
            core_err    <= cmp & wb_err;
            core_rdata  <= (cmp & wb_ack & ~wb_err) ? wb_dat_i : 32'h0;
        end
    end

endmodule
